uart_tx_feeder: RTL

//  Upstream front-end of the UART transmitter. Buffers host bytes and per-byte parity-enable flags in a FIFO.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_feeder_if.sv | 35 +++
 rtl/uart_sync_fifo.sv | 73 +++++++
 rtl/uart_tx_feeder.sv | 104 ++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared definitions for the UART transmit feeder
package uart_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int DEPTH_DEF    = 8;
  localparam int ADDR_W_DEF   = 3;
  localparam int BUSY_TMO_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - host, TX-controller and status signals of the feeder
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_parity_en;
  logic              flush;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_parity_en;
  logic              tx_busy;
  logic [ADDR_W:0]   fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              tx_retry;

  modport master (
    output in_valid, in_data, in_parity_en, flush, tx_busy,
    input  in_ready, tx_valid, tx_data, tx_parity_en,
    input  fifo_count, fifo_empty, fifo_full, tx_retry
  );

  modport slave (
    input  in_valid, in_data, in_parity_en, flush, tx_busy,
    output in_ready, tx_valid, tx_data, tx_parity_en,
    output fifo_count, fifo_empty, fifo_full, tx_retry
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with flush; full/empty decoded from the count
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH  = DATA_W_DEF + 1,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              do_push,  do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push in the flush cycle is dropped rather than landing in the cleared FIFO.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - buffers host bytes and hands them to the TX controller one pulse at a time
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BUSY_TMO = BUSY_TMO_DEF
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_feeder_if.slave bus
);

  localparam int              TMO_W    = $clog2(BUSY_TMO);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);

  feeder_state_e     state_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              tx_valid_q;
  logic              tx_retry_q;
  logic              tx_parity_q;
  logic [DATA_W-1:0] tx_data_q;

  logic [DATA_W:0]   fifo_rdata;
  logic [ADDR_W:0]   fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  // Popping only from IDLE guarantees exactly one FIFO read per delivered byte, retries included.
  assign pop = (state_q == ST_IDLE) && !fifo_empty && !bus.tx_busy;

  uart_sync_fifo #(
    .WIDTH  (DATA_W + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.in_valid),
    .pop_i   (pop),
    .flush_i (bus.flush),
    .wdata_i ({bus.in_parity_en, bus.in_data}),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.in_ready     = !fifo_full;
  assign bus.fifo_count   = fifo_count;
  assign bus.fifo_full    = fifo_full;
  assign bus.fifo_empty   = fifo_empty;
  assign bus.tx_valid     = tx_valid_q;
  assign bus.tx_retry     = tx_retry_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.tx_parity_en = tx_parity_q;

  // tx_valid_q is set on entry to ISSUE, so it is high exactly while the FSM sits in ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_retry_q  <= 1'b0;
      tx_parity_q <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      tx_valid_q <= 1'b0;
      tx_retry_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            tx_data_q   <= fifo_rdata[DATA_W-1:0];
            tx_parity_q <= fifo_rdata[DATA_W];
            tx_valid_q  <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state_q <= ST_WAIT_DONE;
          end else if (tmo_q == TMO_LAST) begin
            tx_retry_q <= 1'b1;
            tx_valid_q <= 1'b1;
            state_q    <= ST_ISSUE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.tx_busy) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
